// File: rtl/eth_rx_frame_ctrl.sv
// Ethernet RX frame sequencer: strips preamble/SFD, feeds the FCS checker,
// collects its CRC verdict and reports per-frame status and statistics.
module eth_rx_frame_ctrl #(
   parameter int unsigned PRE_MIN        = 6,
   parameter int unsigned PRE_MAX        = 7,
   parameter int unsigned MIN_LEN        = 64,
   parameter int unsigned MAX_LEN        = 1518,
   parameter int unsigned RESULT_TIMEOUT = 8
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [7:0]  rx_data,
   input  logic        rx_dv,
   output logic [7:0]  chk_data,
   output logic        chk_valid,
   output logic        chk_sfd_valid,
   input  logic        chk_crc_valid,
   input  logic        chk_crc_error,
   output logic        frame_done,
   output logic        frame_good,
   output logic [15:0] frame_len,
   output logic        err_crc,
   output logic        err_runt,
   output logic        err_giant,
   output logic        err_preamble,
   output logic        err_timeout,
   output logic        rx_overrun,
   output logic [15:0] stat_good_cnt,
   output logic [15:0] stat_bad_cnt
);

   localparam int unsigned LEN_W = 16;
   localparam int unsigned PRE_W = 4;
   localparam int unsigned TMR_W = $clog2(RESULT_TIMEOUT + 1);
   localparam logic [7:0]  PRE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE = 8'hD5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_DATA,
      S_WAIT_RESULT,
      S_COOLDOWN,
      S_DROP
   } state_t;

   state_t           state, state_d;
   logic             rx_dv_q;
   logic             rise;
   logic [PRE_W-1:0] pre_cnt, pre_cnt_d;
   logic [LEN_W-1:0] len_cnt, len_cnt_d;
   logic [TMR_W-1:0] tmr, tmr_d;
   logic             fwd;
   logic             report;
   logic             rep_crc, rep_runt, rep_giant, rep_pre, rep_tmo;
   logic             rep_any_err;
   logic [LEN_W-1:0] rep_len;
   logic             overrun;

   assign rise        = rx_dv & ~rx_dv_q;
   assign rep_any_err = rep_crc | rep_runt | rep_giant | rep_pre | rep_tmo;

   // Next-state, checker forwarding and report decode
   always_comb begin
      state_d   = state;
      pre_cnt_d = pre_cnt;
      len_cnt_d = len_cnt;
      tmr_d     = tmr;
      fwd       = 1'b0;
      report    = 1'b0;
      rep_crc   = 1'b0;
      rep_runt  = 1'b0;
      rep_giant = 1'b0;
      rep_pre   = 1'b0;
      rep_tmo   = 1'b0;
      rep_len   = len_cnt;
      overrun   = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_dv) begin
               // rx_dv already high without a rising edge means we joined mid-frame
               if (!rise) begin
                  state_d = S_DROP;
               end else if (rx_data == PRE_BYTE) begin
                  state_d   = S_PREAMBLE;
                  pre_cnt_d = PRE_W'(1);
               end else begin
                  state_d = S_DROP;
                  report  = 1'b1;
                  rep_pre = 1'b1;
                  rep_len = '0;
               end
            end
         end
         S_PREAMBLE: begin
            if (!rx_dv) begin
               state_d = S_IDLE;
               report  = 1'b1;
               rep_pre = 1'b1;
               rep_len = '0;
            end else if (rx_data == PRE_BYTE) begin
               if (pre_cnt != '1) pre_cnt_d = pre_cnt + 1'b1;
            end else if (rx_data == SFD_BYTE && pre_cnt >= PRE_W'(PRE_MIN)
                         && pre_cnt <= PRE_W'(PRE_MAX)) begin
               state_d   = S_DATA;
               len_cnt_d = '0;
            end else begin
               state_d = S_DROP;
               report  = 1'b1;
               rep_pre = 1'b1;
               rep_len = '0;
            end
         end
         S_DATA: begin
            if (rx_dv) begin
               fwd = 1'b1;
               if (len_cnt != '1) len_cnt_d = len_cnt + 1'b1;
            end else if (len_cnt == '0) begin
               state_d  = S_IDLE;
               report   = 1'b1;
               rep_runt = 1'b1;
            end else begin
               state_d = S_WAIT_RESULT;
               tmr_d   = '0;
            end
         end
         S_WAIT_RESULT: begin
            overrun = rise;
            if (chk_crc_valid || chk_crc_error) begin
               state_d   = S_COOLDOWN;
               report    = 1'b1;
               rep_crc   = chk_crc_error;
               rep_runt  = (len_cnt < LEN_W'(MIN_LEN));
               rep_giant = (len_cnt > LEN_W'(MAX_LEN));
            end else if (tmr == TMR_W'(RESULT_TIMEOUT - 1)) begin
               state_d = S_COOLDOWN;
               report  = 1'b1;
               rep_tmo = 1'b1;
            end else begin
               tmr_d = tmr + 1'b1;
            end
         end
         S_COOLDOWN: begin
            overrun = rise;
            // a frame that started while busy is skipped to its end
            state_d = rx_dv ? S_DROP : S_IDLE;
         end
         S_DROP: begin
            if (!rx_dv) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge aclk) begin
      if (areset) begin
         state         <= S_IDLE;
         rx_dv_q       <= 1'b1;
         pre_cnt       <= '0;
         len_cnt       <= '0;
         tmr           <= '0;
         chk_data      <= '0;
         chk_valid     <= 1'b0;
         chk_sfd_valid <= 1'b0;
         frame_done    <= 1'b0;
         frame_good    <= 1'b0;
         frame_len     <= '0;
         err_crc       <= 1'b0;
         err_runt      <= 1'b0;
         err_giant     <= 1'b0;
         err_preamble  <= 1'b0;
         err_timeout   <= 1'b0;
         rx_overrun    <= 1'b0;
         stat_good_cnt <= '0;
         stat_bad_cnt  <= '0;
      end else begin
         state         <= state_d;
         rx_dv_q       <= rx_dv;
         pre_cnt       <= pre_cnt_d;
         len_cnt       <= len_cnt_d;
         tmr           <= tmr_d;
         chk_valid     <= fwd;
         chk_sfd_valid <= fwd && (len_cnt == '0);
         if (fwd) chk_data <= rx_data;
         frame_done    <= report;
         rx_overrun    <= overrun;
         if (report) begin
            frame_good   <= ~rep_any_err;
            frame_len    <= rep_len;
            err_crc      <= rep_crc;
            err_runt     <= rep_runt;
            err_giant    <= rep_giant;
            err_preamble <= rep_pre;
            err_timeout  <= rep_tmo;
            if (rep_any_err) begin
               if (stat_bad_cnt != '1) stat_bad_cnt <= stat_bad_cnt + 1'b1;
            end else begin
               if (stat_good_cnt != '1) stat_good_cnt <= stat_good_cnt + 1'b1;
            end
         end
      end
   end

   a_sfd_in_valid : assert property (@(posedge aclk) disable iff (areset)
      chk_sfd_valid |-> chk_valid);
   a_good_no_err : assert property (@(posedge aclk) disable iff (areset)
      frame_good |-> !(err_crc | err_runt | err_giant | err_preamble | err_timeout));

endmodule

// File: doc/eth_rx_frame_ctrl.md
Name: eth_rx_frame_ctrl

Overview:
- Sequences the Ethernet RX FCS checker.
- Takes the raw GMII-style byte stream, validates and strips the preamble/SFD, and drives the checker's data and SFD-qualifier inputs.
- Counts frame length, waits for the checker's one-cycle CRC verdict, then issues a per-frame status pulse with error classification and saturating statistics.
- Sits between the PHY byte interface and the RX buffer/commit logic.

Parameters:
PRE_MIN, 6, minimum 0x55 bytes required before SFD
PRE_MAX, 7, maximum 0x55 bytes allowed before SFD
MIN_LEN, 64, minimum frame length in bytes (post-SFD, FCS included)
MAX_LEN, 1518, maximum frame length in bytes (post-SFD, FCS included)
RESULT_TIMEOUT, 8, cycles allowed from last chk_valid to the CRC verdict

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset; also drives checker reset (inverted at integration)
rx_data  in  8  PHY receive byte
rx_dv  in  1  PHY byte valid; high for the whole frame including preamble
chk_data  out  8  byte to FCS checker
chk_valid  out  1  checker byte valid; contiguous for a frame
chk_sfd_valid  out  1  high with the first post-SFD byte only
chk_crc_valid  in  1  checker verdict: CRC good (1-cycle pulse)
chk_crc_error  in  1  checker verdict: CRC bad (1-cycle pulse)
frame_done  out  1  1-cycle status strobe
frame_good  out  1  crc ok and no runt/giant/timeout
frame_len  out  16  post-SFD byte count, saturates at 0xFFFF
err_crc, err_runt, err_giant, err_preamble, err_timeout  out  1 each  classification bits
rx_overrun  out  1  1-cycle pulse: frame ignored because controller busy
stat_good_cnt  out  16  saturating good-frame count
stat_bad_cnt  out  16  saturating bad-frame count

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE.
- If rx_dv is high when reset releases, go to DROP; never lock onto a frame mid-stream.
- Status fields frame_good, frame_len and err_* update only on frame_done and hold until the next frame_done.
- State IDLE: rx_dv rising with rx_data=0x55 -> PREAMBLE, pre_cnt=1. Any other byte -> DROP, report err_preamble.
- State PREAMBLE:
  - 0x55 increments pre_cnt.
  - 0xD5 with PRE_MIN ≤ pre_cnt ≤ PRE_MAX -> DATA.
  - Any other byte, pre_cnt out of range, or rx_dv low -> report err_preamble, len 0. On the byte cases go to DROP; if rx_dv is low go to IDLE.
- State DATA:
  - Each rx_dv byte is registered to chk_data/chk_valid (latency 1 cycle).
  - chk_sfd_valid is high on the first byte only.
  - frame_len increments, saturating.
  - rx_dv low -> WAIT_RESULT, timer cleared. If len==0 (SFD then end), report immediately: err_runt=1, no checker traffic, then IDLE.
- State WAIT_RESULT:
  - Nominal verdict arrives 2 cycles after the last chk_valid.
  - On chk_crc_valid or chk_crc_error, set err_crc=chk_crc_error, err_runt=(len<MIN_LEN), err_giant=(len>MAX_LEN), report, go to COOLDOWN.
  - If the timer reaches RESULT_TIMEOUT, report err_timeout=1 and go to COOLDOWN.
  - Simultaneous crc_valid and crc_error is treated as an error.
- State COOLDOWN: 1 cycle, lets the checker return to idle -> IDLE.
- Reporting:
  - frame_done pulses in the cycle after the triggering condition.
  - frame_good = !(any err_*).
  - stat_good_cnt or stat_bad_cnt increments with frame_done, saturating at 0xFFFF.
- Busy: rx_dv rising in WAIT_RESULT or COOLDOWN -> rx_overrun pulse. The controller enters the DROP flag path: the verdict is still collected and reported, and the new frame's bytes are ignored until rx_dv low. No status is reported for the ignored frame.
- State DROP: ignore bytes until rx_dv low -> IDLE. No chk_valid is issued.
- Giant frames are still forwarded in full so the checker stays aligned.
- Preamble/SFD bytes are never forwarded.

Test Plan:
- 7×0x55, 0xD5, 64-byte frame with correct FCS -> 64 chk_valid cycles, chk_sfd_valid on the first only; frame_done with frame_good=1, frame_len=64; stat_good_cnt=1.
- Same frame with one payload bit flipped -> checker error pulse; frame_done with err_crc=1, frame_good=0; stat_bad_cnt=1.
- 7×0x55, 0xD5, 40-byte valid-FCS frame -> err_runt=1, err_crc=0, frame_len=40. 1600-byte frame -> err_giant=1, all 1600 bytes forwarded.
- Preamble 0x55,0x55,0x5A… -> err_preamble=1, frame_len=0, zero chk_valid. Preamble of 3×0x55 then 0xD5 -> err_preamble.
- Checker verdict inputs held 0 -> err_timeout=1 at RESULT_TIMEOUT+1 cycles after the last byte. New rx_dv rising in the verdict's cooldown cycle -> rx_overrun pulse, frame ignored, no second frame_done.
- areset asserted mid-DATA with rx_dv held high -> outputs 0; after release remain in DROP until rx_dv low; the next clean frame is reported good.
